decode_stage: RTL and testbench

- RV32I decode stage; sits directly downstream of fetch_block and consumes its fetch pipe word (instruction plus PC) through a valid/ready handshake.
- Produces a registered decoded bundle for the execute stage: register indices, sign-extended immediate, instruction class, funct fields, control flags and an illegal-instruction flag.
- Has a 2-entry skid buffer, so in_ready is a registered signal and never depends combinationally on out_ready.
- Flush input discards all in-flight instructions on a redirect.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_stage_imm_gen.sv | 30 +++
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, instruction classes, the decoded bundle.
package decode_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
    CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
  } inst_class_e;

  // Occupancy of the stage: number of valid entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } dec_state_e;

  typedef struct packed {
    inst_class_e        cls;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [INST_W-1:0]  imm;
    logic [2:0]         funct3;
    logic               alt;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
    logic               illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the decoded class.
module imm_gen
  import decode_pkg::*;
(
  input  logic [INST_W-1:7] inst_i,
  input  inst_class_e       cls_i,
  output logic [INST_W-1:0] imm_o
);

  // Format select; R-type and illegal words carry no immediate.
  always_comb begin
    imm_o = '0;
    case (cls_i)
      CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_FENCE, CLS_SYSTEM:
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      CLS_STORE:
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      CLS_BRANCH:
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm_o = {inst_i[31:12], 12'b0};
      CLS_JAL:
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered bundle, with a
// one-entry skid register so in_ready is registered and independent of out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W = 6,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_class,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_funct3,
  output logic            out_alt,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  inst_class_e cls;
  logic [INST_W-1:0] imm;
  decoded_t    dec;

  dec_state_e  state_q, state_d;
  logic        in_ready_q;
  decoded_t    out_q, skid_q;
  logic [PC_W-1:0] out_pc_q, skid_pc_q;
  logic        acc, otx, load_out, load_skid, skid_to_out;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  // Class decode with legality filtering; anything unrecognised is ILLEGAL.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (in_inst[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   if (f3 == 3'b000) cls = CLS_JALR;
        OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) cls = CLS_BRANCH;
        OPC_LOAD:   if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) cls = CLS_LOAD;
        OPC_STORE:  if (f3 < 3'b011) cls = CLS_STORE;
        OPC_OP_IMM: begin
          if (f3 == 3'b001) begin
            if (f7 == 7'b0000000) cls = CLS_OP_IMM;
          end else if (f3 == 3'b101) begin
            if (f7 == 7'b0000000 || f7 == 7'b0100000) cls = CLS_OP_IMM;
          end else begin
            cls = CLS_OP_IMM;
          end
        end
        OPC_OP: begin
          if (f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
            cls = CLS_OP;
        end
        OPC_FENCE:  cls = CLS_FENCE;
        OPC_SYSTEM: cls = CLS_SYSTEM;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
  end

  imm_gen u_imm_gen (
    .inst_i (in_inst[INST_W-1:7]),
    .cls_i  (cls),
    .imm_o  (imm)
  );

  // Assemble the bundle; illegal words keep their raw fields but no side effects.
  always_comb begin
    dec           = '0;
    dec.cls       = cls;
    dec.rd        = in_inst[11:7];
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.imm       = imm;
    dec.funct3    = f3;
    dec.illegal   = (cls == CLS_ILLEGAL);
    dec.alt       = ((cls == CLS_OP) || (cls == CLS_OP_IMM && f3 == 3'b101)) ?
                    in_inst[30] : 1'b0;
    dec.uses_rs1  = !(cls inside {CLS_LUI, CLS_JAL, CLS_ILLEGAL});
    dec.uses_rs2  = (cls inside {CLS_OP, CLS_STORE, CLS_BRANCH});
    dec.writes_rd = (in_inst[11:7] != 5'd0) &&
                    (cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
                                 CLS_LOAD, CLS_OP_IMM, CLS_OP, CLS_SYSTEM});
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign acc       = in_valid && in_ready_q;
  assign otx       = out_valid && out_ready;

  // Occupancy FSM: decides which register loads; flush wins over everything.
  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          state_d  = ST_ONE;
          load_out = 1'b1;
        end
        ST_ONE: begin
          if (acc && otx) begin
            load_out = 1'b1;
          end else if (acc) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (otx) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (otx) begin
          state_d     = ST_ONE;
          skid_to_out = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, ready and data registers; reset also clears the bundle contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      out_pc_q   <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_out) begin
        out_q    <= dec;
        out_pc_q <= in_pc;
      end else if (skid_to_out) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc_q;
      end
      if (load_skid) begin
        skid_q    <= dec;
        skid_pc_q <= in_pc;
      end
    end
  end

  assign out_pc        = out_pc_q;
  assign out_class     = out_q.cls;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_funct3    = out_q.funct3;
  assign out_alt       = out_q.alt;
  assign out_uses_rs1  = out_q.uses_rs1;
  assign out_uses_rs2  = out_q.uses_rs2;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hand sequences for skid/flush/reset,
// then randomized traffic against a queue-based reference model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, out_imm;
  logic [5:0]  in_pc, out_pc;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_alt, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  logic [64:0] dut_b;

  int checks = 0;
  int failures = 0;

  decode_stage #(.PC_W(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  assign dut_b = {out_class, out_rd, out_rs1, out_rs2, out_imm, out_funct3, out_alt,
                  out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal, out_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        alt, u1, u2, wr, ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic [4:0]  rd, rs1;
    logic [4:0]  flags;   // {alt, uses_rs1, uses_rs2, writes_rd, illegal}
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  pc;
  } ent_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decoder written directly from the ISA rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t e;
    int s;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok;
    s  = int'(inst);
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    e = '0;
    e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.f3 = f3;
    ok = 1'b1;
    e.cls = CLS_ILLEGAL;
    case (op)
      7'h37: e.cls = CLS_LUI;
      7'h17: e.cls = CLS_AUIPC;
      7'h6F: e.cls = CLS_JAL;
      7'h67: begin e.cls = CLS_JALR;   ok = (f3 == 0); end
      7'h63: begin e.cls = CLS_BRANCH; ok = !(f3 == 2 || f3 == 3); end
      7'h03: begin e.cls = CLS_LOAD;   ok = !(f3 == 3 || f3 >= 6); end
      7'h23: begin e.cls = CLS_STORE;  ok = (f3 < 3); end
      7'h13: begin
        e.cls = CLS_OP_IMM;
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
      end
      7'h33: begin e.cls = CLS_OP; ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
      7'h0F: e.cls = CLS_FENCE;
      7'h73: e.cls = CLS_SYSTEM;
      default: ok = 1'b0;
    endcase
    if (inst[1:0] != 2'b11) ok = 1'b0;
    if (!ok) begin
      e.cls = CLS_ILLEGAL;
      e.ill = 1'b1;
      return e;
    end
    case (e.cls)
      CLS_LUI, CLS_AUIPC: e.imm = inst & 32'hFFFFF000;
      CLS_JAL: e.imm = 32'(((s >>> 31) << 20) | (((s >> 12) & 255) << 12) |
                           (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1));
      CLS_BRANCH: e.imm = 32'(((s >>> 31) << 12) | (((s >> 7) & 1) << 11) |
                              (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1));
      CLS_STORE: e.imm = 32'(((s >>> 25) << 5) | ((s >> 7) & 31));
      CLS_OP:    e.imm = 32'd0;
      default:   e.imm = 32'(s >>> 20);
    endcase
    e.u1  = !(e.cls == CLS_LUI || e.cls == CLS_JAL);
    e.u2  = (e.cls == CLS_OP || e.cls == CLS_STORE || e.cls == CLS_BRANCH);
    e.wr  = (e.rd != 0) && !(e.cls == CLS_BRANCH || e.cls == CLS_STORE || e.cls == CLS_FENCE);
    e.alt = (e.cls == CLS_OP || (e.cls == CLS_OP_IMM && f3 == 5)) ? inst[30] : 1'b0;
    return e;
  endfunction

  function automatic logic [64:0] pack(input exp_t e, input logic [5:0] pc);
    return {e.cls, e.rd, e.rs1, e.rs2, e.imm, e.f3, e.alt, e.u1, e.u2, e.wr, e.ill, pc};
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] opcs [11];
    logic [31:0] w;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  vec_t vecs [14];
  ent_t q [$];

  initial begin
    exp_t e;
    ent_t en;
    bit rdy, otx, acc;

    vecs = '{
      '{32'h00500093, CLS_OP_IMM,  32'h00000005,  5'd1,  5'd0, 5'b01010},
      '{32'hFFF10113, CLS_OP_IMM,  32'hFFFFFFFF,  5'd2,  5'd2, 5'b01010},
      '{32'hFE000EE3, CLS_BRANCH,  32'hFFFFFFFC, 5'd29,  5'd0, 5'b01100},
      '{32'h00000000, CLS_ILLEGAL, 32'h00000000,  5'd0,  5'd0, 5'b00001},
      '{32'h02000033, CLS_ILLEGAL, 32'h00000000,  5'd0,  5'd0, 5'b00001},
      '{32'h123452B7, CLS_LUI,     32'h12345000,  5'd5,  5'd8, 5'b00010},
      '{32'h402081B3, CLS_OP,      32'h00000000,  5'd3,  5'd1, 5'b11110},
      '{32'h0020A423, CLS_STORE,   32'h00000008,  5'd8,  5'd1, 5'b01100},
      '{32'hFFDFF06F, CLS_JAL,     32'hFFFFFFFC,  5'd0, 5'd31, 5'b00000},
      '{32'h0000B003, CLS_ILLEGAL, 32'h00000000,  5'd0,  5'd1, 5'b00001},
      '{32'h4032D293, CLS_OP_IMM,  32'h00000403,  5'd5,  5'd5, 5'b11010},
      '{32'h40329293, CLS_ILLEGAL, 32'h00000000,  5'd5,  5'd5, 5'b00001},
      '{32'h00009067, CLS_ILLEGAL, 32'h00000000,  5'd0,  5'd1, 5'b00001},
      '{32'h000080E7, CLS_JALR,    32'h00000000,  5'd1,  5'd1, 5'b01010}
    };

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_bundle", dut_b, 65'd0);

    // Back-to-back stream of the decode table with out_ready held high.
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        chk("vec_valid", out_valid, 1'b1);
        chk("vec_ready", in_ready, 1'b1);
        chk("vec_pc", out_pc, 6'(k + 2));
        chk("vec_class", out_class, vecs[k-1].cls);
        chk("vec_imm", out_imm, vecs[k-1].imm);
        chk("vec_rd", out_rd, vecs[k-1].rd);
        chk("vec_rs1", out_rs1, vecs[k-1].rs1);
        chk("vec_flags", {out_alt, out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal},
            vecs[k-1].flags);
        chk("vec_model", dut_b, pack(ref_decode(vecs[k-1].inst), 6'(k + 2)));
      end
      if (k < 14) begin
        in_valid = 1'b1; in_inst = vecs[k].inst; in_pc = 6'(k + 3);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("drain_valid", out_valid, 1'b0);

    // Skid: three requests while execute stalls, then release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 6'd10;
    tick();
    chk("skid_v1", out_valid, 1'b1); chk("skid_r1", in_ready, 1'b1); chk("skid_pc1", out_pc, 6'd10);
    in_inst = 32'hFFF10113; in_pc = 6'd11;
    tick();
    chk("skid_r2", in_ready, 1'b0); chk("skid_pc2", out_pc, 6'd10);
    in_inst = 32'h402081B3; in_pc = 6'd12;
    tick();
    chk("skid_r3", in_ready, 1'b0); chk("skid_hold", out_pc, 6'd10); chk("skid_rd_hold", out_rd, 5'd1);
    out_ready = 1'b1;
    tick();
    chk("skid_pc4", out_pc, 6'd11); chk("skid_rd4", out_rd, 5'd2); chk("skid_r4", in_ready, 1'b1);
    tick();
    chk("skid_pc5", out_pc, 6'd12); chk("skid_rd5", out_rd, 5'd3); chk("skid_v5", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("skid_empty", out_valid, 1'b0); chk("skid_r6", in_ready, 1'b1);

    // Flush while FULL with a concurrent input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 6'd20;
    tick();
    in_pc = 6'd21;
    tick();
    chk("fl_full", in_ready, 1'b0);
    flush = 1'b1; in_pc = 6'd22;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid", out_valid, 1'b0); chk("fl_ready", in_ready, 1'b1);
    repeat (2) begin
      tick();
      chk("fl_quiet", out_valid, 1'b0);
    end

    // Flush while ONE with an input that would otherwise be accepted.
    in_valid = 1'b1; in_pc = 6'd30;
    tick();
    flush = 1'b1; in_pc = 6'd31;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_valid", out_valid, 1'b0);
    tick();
    chk("fl1_quiet", out_valid, 1'b0);

    // Reset while ONE clears the bundle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 6'd40;
    tick();
    chk("rst_pre", out_valid, 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 1'b0); chk("rst_bundle", dut_b, 65'd0); chk("rst_ready", in_ready, 1'b1);

    // Randomized traffic against an occupancy-2 FIFO model.
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        e = ref_decode(q[0].inst);
        chk("rnd_bundle", dut_b, pack(e, q[0].pc));
      end
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = gen_inst();
      in_pc     = 6'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (rst || flush) begin
        q.delete();
      end else begin
        rdy = (q.size() < 2);
        otx = (q.size() > 0) && out_ready;
        acc = in_valid && rdy;
        if (otx) void'(q.pop_front());
        if (acc) begin
          en.inst = in_inst; en.pc = in_pc;
          q.push_back(en);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
